// File: rtl/skew_ram_feeder.sv
// Banked RAM that streams one word per lane per cycle, skewed diagonally so that
// lane i trails lane 0 by i cycles, as required at the edge of a systolic array.
module skew_ram_feeder #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int LANES  = 2,
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [LANE_W-1:0]       wr_lane,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_err,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base,
   input  logic [ADDR_W:0]         len,
   output logic                    busy,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES-1:0]        out_valid,
   output logic                    done
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int NTAP  = LANES * (LANES + 1) / 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, next_state;

   logic [DATA_W-1:0] mem [LANES][DEPTH] = '{default: '0};

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   k;
   logic [ADDR_W:0]   len_clamp;
   logic [ADDR_W-1:0] rd_addr;
   logic              lane_ok;
   logic              wr_ok;
   logic              start_ok;
   logic              rd_en;
   logic              last_read;

   // Triangular skew storage: lane i owns taps i*(i+1)/2 .. i*(i+1)/2+i, the first
   // being its read-stage register and the last driving the lane output.
   logic [DATA_W-1:0] tap_data [NTAP];
   logic [NTAP-1:0]   tap_valid;
   logic [NTAP-1:0]   tap_last;

   always_comb begin
      busy      = (state != IDLE);
      lane_ok   = int'(wr_lane) < LANES;
      wr_ok     = wr_en && !busy && lane_ok;
      len_clamp = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
      start_ok  = (state == IDLE) && start && (len != '0);
      rd_en     = (state == RUN);
      last_read = rd_en && (k == len_q - (ADDR_W+1)'(1));
      rd_addr   = base_q + k[ADDR_W-1:0];
      done      = tap_valid[NTAP-1] && tap_last[NTAP-1];
   end

   // DRAIN is left only once the last lane has shown its final word.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_ok)  next_state = RUN;
         RUN:     if (last_read) next_state = DRAIN;
         DRAIN:   if (done)      next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         base_q <= '0;
         len_q  <= '0;
         k      <= '0;
         wr_err <= 1'b0;
      end else begin
         state  <= next_state;
         wr_err <= wr_en && !wr_ok;
         if (start_ok) begin
            base_q <= base;
            len_q  <= len_clamp;
            k      <= '0;
         end else if (rd_en) begin
            k <= k + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_lane][wr_addr] <= wr_data;
      end
   end

   // Idle cycles load zero data so every lane reads 0 whenever it is not valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NTAP; t++) begin
            tap_data[t] <= '0;
         end
         tap_valid <= '0;
         tap_last  <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j <= i; j++) begin
               if (j == 0) begin
                  tap_data[i*(i+1)/2]  <= rd_en ? mem[i][rd_addr] : '0;
                  tap_valid[i*(i+1)/2] <= rd_en;
                  tap_last[i*(i+1)/2]  <= last_read;
               end else begin
                  tap_data[i*(i+1)/2+j]  <= tap_data[i*(i+1)/2+j-1];
                  tap_valid[i*(i+1)/2+j] <= tap_valid[i*(i+1)/2+j-1];
                  tap_last[i*(i+1)/2+j]  <= tap_last[i*(i+1)/2+j-1];
               end
            end
         end
      end
   end

   always_comb begin
      out_data  = '0;
      out_valid = '0;
      for (int i = 0; i < LANES; i++) begin
         out_data[i*DATA_W +: DATA_W] = tap_data[i*(i+1)/2+i];
         out_valid[i]                 = tap_valid[i*(i+1)/2+i];
      end
   end

endmodule

// File: tb/tb_skew_ram_feeder.sv
// Scoreboard bench for skew_ram_feeder: a two-lane instance carries most scenarios,
// a three-lane instance covers out-of-range lane writes and deeper skew.
module tb_skew_ram_feeder;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int NL    = 2;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [0:0]        wr_lane;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              wr_err;
   logic              start;
   logic [AW-1:0]     base;
   logic [AW:0]       len;
   logic              busy;
   logic [NL*DW-1:0]  out_data;
   logic [NL-1:0]     out_valid;
   logic              done;

   logic              wr_en3;
   logic [1:0]        wr_lane3;
   logic [AW-1:0]     wr_addr3;
   logic [DW-1:0]     wr_data3;
   logic              wr_err3;
   logic              start3;
   logic [AW-1:0]     base3;
   logic [AW:0]       len3;
   logic              busy3;
   logic [3*DW-1:0]   out_data3;
   logic [2:0]        out_valid3;
   logic              done3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_idle = 0;
   int s3;

   typedef struct {
      int lane;
      int data;
      int cyc;
   } exp_t;

   exp_t          lane_q[$];
   int            done_q[$];
   logic [DW-1:0] model [NL][DEPTH];

   skew_ram_feeder #(.DATA_W(DW), .ADDR_W(AW), .LANES(NL)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err), .start(start), .base(base), .len(len),
      .busy(busy), .out_data(out_data), .out_valid(out_valid), .done(done)
   );

   skew_ram_feeder #(.DATA_W(DW), .ADDR_W(AW), .LANES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_lane(wr_lane3), .wr_addr(wr_addr3),
      .wr_data(wr_data3), .wr_err(wr_err3), .start(start3), .base(base3), .len(len3),
      .busy(busy3), .out_data(out_data3), .out_valid(out_valid3), .done(done3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic writeWord(input int lane, input int addr, input int data, input bit exp_err);
      wr_en   = 1'b1;
      wr_lane = 1'(lane);
      wr_addr = AW'(addr);
      wr_data = DW'(data);
      @(negedge clk);
      checkOutput("wr_err", wr_err, exp_err);
      if (!exp_err) model[lane][addr] = DW'(data);
      wr_en = 1'b0;
   endtask

   task automatic applyStimulus(input int b, input int l, input bit accept);
      int s;
      int lc;
      int kk;
      start = 1'b1;
      base  = AW'(b);
      len   = (AW+1)'(l);
      s     = cyc + 1;
      lc    = (l > DEPTH) ? DEPTH : l;
      if (accept) begin
         for (int t = s + 1; t <= s + lc + NL - 1; t++) begin
            for (int i = 0; i < NL; i++) begin
               kk = t - s - 1 - i;
               if (kk >= 0 && kk < lc)
                  lane_q.push_back('{lane: i, data: int'(model[i][(b + kk) % DEPTH]), cyc: t});
            end
         end
         done_q.push_back(s + lc + NL - 1);
         last_idle = s + lc + NL;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("idle_timeout", 0, 1);
      else      checkOutput("idle_cycle", cyc, last_idle);
      checkOutput("lane_q_left", lane_q.size(), 0);
      checkOutput("done_q_left", done_q.size(), 0);
   endtask

   // Scoreboard monitor: pops one expected word per valid lane, in lane order.
   always @(negedge clk) begin
      exp_t e;
      int   dc;
      if (rst_n) begin
         for (int i = 0; i < NL; i++) begin
            if (out_valid[i]) begin
               if (lane_q.size() == 0) begin
                  checkOutput("lane_unexpected_valid", 1, 0);
               end else begin
                  e = lane_q.pop_front();
                  checkOutput("lane_id", i, e.lane);
                  checkOutput("lane_data", out_data[i*DW +: DW], e.data);
                  checkOutput("lane_cycle", cyc, e.cyc);
               end
            end else begin
               checkOutput("lane_idle_zero", out_data[i*DW +: DW], 0);
            end
         end
         if (done) begin
            checkOutput("busy_in_done", busy, 1);
            if (done_q.size() == 0) begin
               checkOutput("done_unexpected", 1, 0);
            end else begin
               dc = done_q.pop_front();
               checkOutput("done_cycle", cyc, dc);
            end
         end
      end
   end

   initial begin
      #500000;
      checkOutput("global_timeout", 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0;
      start = 1'b0; base = '0; len = '0;
      wr_en3 = 1'b0; wr_lane3 = '0; wr_addr3 = '0; wr_data3 = '0;
      start3 = 1'b0; base3 = '0; len3 = '0;
      for (int l = 0; l < NL; l++)
         for (int a = 0; a < DEPTH; a++)
            model[l][a] = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_wr_err", wr_err, 0);
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_data", out_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic two-lane stream
      writeWord(0, 0, 1, 0);
      writeWord(0, 1, 3, 0);
      writeWord(1, 0, 2, 0);
      writeWord(1, 1, 4, 0);
      applyStimulus(0, 2, 1);
      waitIdle();

      // Address wrap-around
      writeWord(0, 15, 7, 0);
      writeWord(0, 0, 9, 0);
      writeWord(1, 15, 'h15, 0);
      writeWord(1, 0, 'h20, 0);
      applyStimulus(15, 2, 1);
      waitIdle();

      // Write while busy is rejected and leaves memory untouched
      applyStimulus(0, 4, 1);
      writeWord(0, 1, 5, 1);
      @(negedge clk);
      checkOutput("wr_err_pulse_end", wr_err, 0);
      waitIdle();
      applyStimulus(0, 2, 1);
      waitIdle();

      // Zero length is ignored
      applyStimulus(3, 0, 0);
      checkOutput("len0_busy", busy, 0);
      repeat (3) @(negedge clk);
      checkOutput("len0_busy_later", busy, 0);
      checkOutput("len0_no_output", lane_q.size() + done_q.size(), 0);

      // Full memory with random data, then over-long lengths clamp to depth
      for (int a = 0; a < DEPTH; a++)
         for (int l = 0; l < NL; l++)
            writeWord(l, a, int'($urandom_range(0, 65535)), 0);
      applyStimulus(0, 20, 1);
      waitIdle();
      applyStimulus(6, 17, 1);
      waitIdle();

      // Start held through DRAIN and the done cycle is ignored, then accepted
      applyStimulus(2, 3, 1);
      repeat (3) @(negedge clk);
      start = 1'b1; base = 4'd9; len = 5'd5;
      repeat (2) @(negedge clk);
      applyStimulus(4, 2, 1);
      waitIdle();

      // Reset mid-stream aborts with no done, then a new stream works
      applyStimulus(0, 8, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_done", done, 0);
      checkOutput("midreset_valid", out_valid, 0);
      checkOutput("midreset_data", out_data, 0);
      checkOutput("midreset_wr_err", wr_err, 0);
      lane_q.delete();
      done_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("post_reset_busy", busy, 0);
      applyStimulus(5, 3, 1);
      waitIdle();

      // Three-lane instance: out-of-range lane write and three-step skew
      wr_en3 = 1'b1; wr_lane3 = 2'd3; wr_addr3 = '0; wr_data3 = 16'h55;
      @(negedge clk);
      checkOutput("lane3_wr_err", wr_err3, 1);
      wr_lane3 = 2'd2; wr_data3 = 16'hAB;
      @(negedge clk);
      checkOutput("lane2_wr_ok", wr_err3, 0);
      wr_en3 = 1'b0;
      start3 = 1'b1; base3 = '0; len3 = 5'd1;
      s3 = cyc + 1;
      @(negedge clk);
      start3 = 1'b0;
      checkOutput("l3_busy", busy3, 1);
      @(negedge clk);
      checkOutput("l3_valid_s1", out_valid3, 3'b001);
      @(negedge clk);
      checkOutput("l3_valid_s2", out_valid3, 3'b010);
      @(negedge clk);
      checkOutput("l3_valid_s3", out_valid3, 3'b100);
      checkOutput("l3_lane2_data", out_data3[2*DW +: DW], 16'hAB);
      checkOutput("l3_done", done3, 1);
      checkOutput("l3_done_cycle", cyc, s3 + 3);
      @(negedge clk);
      checkOutput("l3_idle", busy3, 0);
      checkOutput("l3_valid_after", out_valid3, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
